// File: rtl/rf_access_ctrl.sv
// Register-file initiator: valid/ready requests -> registered RF strobes; reads respond 1 edge after the strobe cycle.
// Latency accept->strobe 1 cycle, ->RSP_VALID 2 edges; a stalled response (RSP_READY=0) holds REQ_READY low.
module rf_access_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 5,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_r1,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_r2,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_w,
  input  logic [DATA_WIDTH-1:0] i_req_data_w,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data_r1,
  output logic [DATA_WIDTH-1:0] o_rsp_data_r2,
  output logic                  o_rsp_last,
  input  logic                  i_dump_start,
  output logic                  o_dump_busy,
  output logic                  o_rf_read,
  output logic                  o_rf_write,
  output logic [ADDR_WIDTH-1:0] o_rf_addr_r1,
  output logic [ADDR_WIDTH-1:0] o_rf_addr_r2,
  output logic [ADDR_WIDTH-1:0] o_rf_addr_w,
  output logic [DATA_WIDTH-1:0] o_rf_data_w,
  input  logic [DATA_WIDTH-1:0] i_rf_data_r1,
  input  logic [DATA_WIDTH-1:0] i_rf_data_r2
);

  localparam int KW = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_WR_ISSUE, S_RSP_WAIT, S_DUMP_ISSUE, S_DUMP_RSP
  } state_t;

  state_t                r_state, w_state;
  logic [KW-1:0]         r_k, w_k;
  logic                  r_req_ready, w_req_ready;
  logic                  r_rsp_valid, w_rsp_valid;
  logic                  r_rsp_last, w_rsp_last;
  logic                  r_dump_busy, w_dump_busy;
  logic                  r_rf_read, w_rf_read;
  logic                  r_rf_write, w_rf_write;
  logic [ADDR_WIDTH-1:0] r_rf_addr_r1, w_rf_addr_r1;
  logic [ADDR_WIDTH-1:0] r_rf_addr_r2, w_rf_addr_r2;
  logic [ADDR_WIDTH-1:0] r_rf_addr_w, w_rf_addr_w;
  logic [DATA_WIDTH-1:0] r_rf_data_w, w_rf_data_w;
  logic [DATA_WIDTH-1:0] r_rsp_data_r1, w_rsp_data_r1;
  logic [DATA_WIDTH-1:0] r_rsp_data_r2, w_rsp_data_r2;

  always_comb begin
    w_state       = r_state;
    w_k           = r_k;
    w_rsp_valid   = r_rsp_valid;
    w_rsp_last    = r_rsp_last;
    w_rf_write    = 1'b0;
    w_rf_addr_r1  = r_rf_addr_r1;
    w_rf_addr_r2  = r_rf_addr_r2;
    w_rf_addr_w   = r_rf_addr_w;
    w_rf_data_w   = r_rf_data_w;
    w_rsp_data_r1 = r_rsp_data_r1;
    w_rsp_data_r2 = r_rsp_data_r2;
    case (r_state)
      S_IDLE: begin
        // A completed handshake is honoured; a dump waits for the next idle cycle in that case.
        if (r_req_ready && i_req_valid) begin
          if (i_req_write) begin
            w_state     = S_WR_ISSUE;
            w_rf_addr_w = i_req_addr_w;
            w_rf_data_w = i_req_data_w;
            w_rf_write  = !(ZERO_REG_PROTECT && (i_req_addr_w == '0));
          end else begin
            w_state      = S_RD_ISSUE;
            w_rf_addr_r1 = i_req_addr_r1;
            w_rf_addr_r2 = i_req_addr_r2;
          end
        end else if (i_dump_start) begin
          w_state      = S_DUMP_ISSUE;
          w_k          = '0;
          w_rf_addr_r1 = '0;
          w_rf_addr_r2 = {{KW{1'b0}}, 1'b1};
        end
      end
      S_RD_ISSUE: begin
        w_state       = S_RSP_WAIT;
        w_rsp_valid   = 1'b1;
        w_rsp_last    = 1'b0;
        w_rsp_data_r1 = i_rf_data_r1;
        w_rsp_data_r2 = i_rf_data_r2;
      end
      S_WR_ISSUE: w_state = S_IDLE;
      S_RSP_WAIT: begin
        if (i_rsp_ready) begin
          w_state     = S_IDLE;
          w_rsp_valid = 1'b0;
        end
      end
      S_DUMP_ISSUE: begin
        w_state       = S_DUMP_RSP;
        w_rsp_valid   = 1'b1;
        w_rsp_last    = (r_k == {KW{1'b1}});
        w_rsp_data_r1 = i_rf_data_r1;
        w_rsp_data_r2 = i_rf_data_r2;
      end
      S_DUMP_RSP: begin
        if (i_rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_rsp_last  = 1'b0;
          if (r_k == {KW{1'b1}}) begin
            w_state = S_IDLE;
            w_k     = '0;
          end else begin
            w_state      = S_DUMP_ISSUE;
            w_k          = r_k + 1'b1;
            w_rf_addr_r1 = {w_k, 1'b0};
            w_rf_addr_r2 = {w_k, 1'b1};
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_rf_read   = (w_state == S_RD_ISSUE) || (w_state == S_DUMP_ISSUE);
    w_dump_busy = (w_state == S_DUMP_ISSUE) || (w_state == S_DUMP_RSP);
    w_req_ready = (w_state == S_IDLE) && !i_dump_start;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_last    <= 1'b0;
      r_dump_busy   <= 1'b0;
      r_rf_read     <= 1'b0;
      r_rf_write    <= 1'b0;
      r_rf_addr_r1  <= '0;
      r_rf_addr_r2  <= '0;
      r_rf_addr_w   <= '0;
      r_rf_data_w   <= '0;
      r_rsp_data_r1 <= '0;
      r_rsp_data_r2 <= '0;
    end else begin
      r_state       <= w_state;
      r_k           <= w_k;
      r_req_ready   <= w_req_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_last    <= w_rsp_last;
      r_dump_busy   <= w_dump_busy;
      r_rf_read     <= w_rf_read;
      r_rf_write    <= w_rf_write;
      r_rf_addr_r1  <= w_rf_addr_r1;
      r_rf_addr_r2  <= w_rf_addr_r2;
      r_rf_addr_w   <= w_rf_addr_w;
      r_rf_data_w   <= w_rf_data_w;
      r_rsp_data_r1 <= w_rsp_data_r1;
      r_rsp_data_r2 <= w_rsp_data_r2;
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_last    = r_rsp_last;
  assign o_dump_busy   = r_dump_busy;
  assign o_rf_read     = r_rf_read;
  assign o_rf_write    = r_rf_write;
  assign o_rf_addr_r1  = r_rf_addr_r1;
  assign o_rf_addr_r2  = r_rf_addr_r2;
  assign o_rf_addr_w   = r_rf_addr_w;
  assign o_rf_data_w   = r_rf_data_w;
  assign o_rsp_data_r1 = r_rsp_data_r1;
  assign o_rsp_data_r2 = r_rsp_data_r2;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 32x32 register file attached.
module tb_rf_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [4:0]  req_addr_r1 = '0, req_addr_r2 = '0, req_addr_w = '0;
  logic [31:0] req_data_w = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_last;
  logic [31:0] rsp_data_r1, rsp_data_r2;
  logic        dump_start = 1'b0, dump_busy;
  logic        rf_read, rf_write;
  logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
  logic [31:0] rf_data_w, rf_data_r1, rf_data_r2;

  logic [31:0] mem [32];
  logic        mem_clr = 1'b1;
  int          wr_pulses;
  int          both_cnt;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rf_access_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr_r1(req_addr_r1), .i_req_addr_r2(req_addr_r2), .i_req_addr_w(req_addr_w),
    .i_req_data_w(req_data_w),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data_r1(rsp_data_r1), .o_rsp_data_r2(rsp_data_r2), .o_rsp_last(rsp_last),
    .i_dump_start(dump_start), .o_dump_busy(dump_busy),
    .o_rf_read(rf_read), .o_rf_write(rf_write),
    .o_rf_addr_r1(rf_addr_r1), .o_rf_addr_r2(rf_addr_r2), .o_rf_addr_w(rf_addr_w),
    .o_rf_data_w(rf_data_w), .i_rf_data_r1(rf_data_r1), .i_rf_data_r2(rf_data_r2)
  );

  assign rf_data_r1 = mem[rf_addr_r1];
  assign rf_data_r2 = mem[rf_addr_r2];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      wr_pulses <= 0;
      both_cnt  <= 0;
    end else begin
      if (rf_write) begin
        mem[rf_addr_w] <= rf_data_w;
        wr_pulses      <= wr_pulses + 1;
      end
      if (rf_read && rf_write) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_timeout got=%b exp=1", name, req_ready);
    end
  endtask

  // Drives one write; returns just after the accepting edge (strobe cycle visible).
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wait_ready("wr");
    req_valid = 1'b1; req_write = 1'b1; req_addr_w = a; req_data_w = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Drives one read; returns with the response expected on the outputs.
  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    wait_ready("rd");
    req_valid = 1'b1; req_write = 1'b0; req_addr_r1 = a1; req_addr_r2 = a2;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    tick();
    n_tests++;
    if ({req_ready, rsp_valid, rsp_last, dump_busy, rf_read, rf_write} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {req_ready, rsp_valid, rsp_last, dump_busy, rf_read, rf_write});
    end
    n_tests++;
    if ({rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, rsp_data_r1, rsp_data_r2} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h/%h exp=0",
               rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, rsp_data_r1, rsp_data_r2);
    end
    rst_n = 1'b1; mem_clr = 1'b0;
    tick();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEADBEEF);
    n_tests++;
    if ({rf_write, rf_read, req_ready} !== 3'b100 || rf_addr_w !== 5'd5 || rf_data_w !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_strobe got=w%b r%b rdy%b a=%0d d=%h exp=w1 r0 rdy0 a=5 d=deadbeef",
               rf_write, rf_read, req_ready, rf_addr_w, rf_data_w);
    end
    tick();
    n_tests++;
    if (rf_write !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_period got=w%b rdy%b exp=w0 rdy1", rf_write, req_ready);
    end
    req_valid = 1'b1; req_addr_r1 = 5'd5; req_addr_r2 = 5'd0;
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (rf_read !== 1'b1 || rf_addr_r1 !== 5'd5 || rf_addr_r2 !== 5'd0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_strobe got=r%b a1=%0d a2=%0d v%b exp=r1 a1=5 a2=0 v0",
               rf_read, rf_addr_r1, rf_addr_r2, rsp_valid);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data_r1 !== 32'hDEADBEEF || rsp_data_r2 !== 32'h0 ||
        rsp_last !== 1'b0 || rf_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rsp got=v%b d1=%h d2=%h l%b r%b exp=v1 d1=deadbeef d2=0 l0 r0",
               rsp_valid, rsp_data_r1, rsp_data_r2, rsp_last, rf_read);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_done got=v%b rdy%b exp=v0 rdy1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_zero_protect();
    int w0;
    w0 = wr_pulses;
    wr(5'd0, 32'h12345678);
    tick();
    tick();
    n_tests++;
    if (wr_pulses !== w0) begin
      n_fail++;
      $display("FAIL zero_no_strobe got=%0d exp=%0d", wr_pulses, w0);
    end
    rd(5'd0, 5'd5);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data_r1 !== 32'h0 || rsp_data_r2 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL zero_readback got=v%b d1=%h d2=%h exp=v1 d1=0 d2=deadbeef",
               rsp_valid, rsp_data_r1, rsp_data_r2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    wr(5'd9, 32'hA5A5_0009);
    tick();
    rd(5'd9, 5'd5);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data_r1 !== 32'hA5A5_0009 ||
          rsp_data_r2 !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got=v%b rdy%b d1=%h d2=%h exp=v1 rdy0 d1=a5a50009 d2=deadbeef",
                 c, rsp_valid, req_ready, rsp_data_r1, rsp_data_r2);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got=v%b rdy%b exp=v0 rdy1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_dump();
    int ready_seen;
    logic [31:0] e1, e2;
    for (int n = 0; n < 32; n++) wr(n[4:0], 32'h100 + n);
    tick();
    ready_seen = 0;
    dump_start = 1'b1;
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr_r1 = 5'd3; req_addr_r2 = 5'd4;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (rf_read !== 1'b1 || rf_addr_r1 !== 5'(2 * k) || rf_addr_r2 !== 5'(2 * k + 1) ||
          dump_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL dump_issue_%0d got=r%b a1=%0d a2=%0d b%b exp=r1 a1=%0d a2=%0d b1",
                 k, rf_read, rf_addr_r1, rf_addr_r2, dump_busy, 2 * k, 2 * k + 1);
      end
      if (req_ready) ready_seen++;
      tick();
      // r0 is write-protected, so it keeps its cleared value.
      e1 = (k == 0) ? 32'h0 : 32'h100 + 2 * k;
      e2 = 32'h100 + 2 * k + 1;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data_r1 !== e1 || rsp_data_r2 !== e2 ||
          rsp_last !== (k == 15)) begin
        n_fail++;
        $display("FAIL dump_rsp_%0d got=v%b d1=%h d2=%h l%b exp=v1 d1=%h d2=%h l%b",
                 k, rsp_valid, rsp_data_r1, rsp_data_r2, rsp_last, e1, e2, (k == 15));
      end
      if (req_ready) ready_seen++;
      if (k == 0) dump_start = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    n_tests++;
    if (ready_seen !== 0) begin
      n_fail++;
      $display("FAIL dump_req_blocked got=%0d exp=0", ready_seen);
    end
    n_tests++;
    if (dump_busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dump_end got=b%b v%b l%b rdy%b exp=b0 v0 l0 rdy1",
               dump_busy, rsp_valid, rsp_last, req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (rf_read !== 1'b1 || rf_addr_r1 !== 5'd3 || rf_addr_r2 !== 5'd4) begin
      n_fail++;
      $display("FAIL dump_then_req got=r%b a1=%0d a2=%0d exp=r1 a1=3 a2=4", rf_read, rf_addr_r1, rf_addr_r2);
    end
    tick();
    n_tests++;
    if (rsp_data_r1 !== 32'h103 || rsp_data_r2 !== 32'h104) begin
      n_fail++;
      $display("FAIL dump_then_rsp got=%h/%h exp=103/104", rsp_data_r1, rsp_data_r2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data_r2 !== 32'h10F) begin
      n_fail++;
      $display("FAIL mid_dump_k7 got=v%b d2=%h exp=v1 d2=10f", rsp_valid, rsp_data_r2);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (rsp_valid !== 1'b0 || dump_busy !== 1'b0 || rf_read !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got=v%b b%b r%b exp=v0 b0 r0", rsp_valid, dump_busy, rf_read);
    end
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    n_tests++;
    if (rf_read !== 1'b1 || rf_addr_r1 !== 5'd0 || rf_addr_r2 !== 5'd1) begin
      n_fail++;
      $display("FAIL redump_k0 got=r%b a1=%0d a2=%0d exp=r1 a1=0 a2=1", rf_read, rf_addr_r1, rf_addr_r2);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data_r2 !== 32'h101 || rsp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL redump_rsp0 got=v%b d2=%h l%b exp=v1 d2=101 l0", rsp_valid, rsp_data_r2, rsp_last);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (dump_busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL redump_done got=b%b rdy%b exp=b0 rdy1", dump_busy, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_protect();
    test_rsp_backpressure();
    test_dump();
    test_reset_mid_dump();
    n_tests++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL read_write_overlap got=%0d exp=0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
